// File: rtl/multiply_divide_unit.sv
// Sequential HI/LO engine: 32-step shift-add multiply and restoring divide,
// plus single-cycle MTHI/MTLO writes into the architectural HI/LO registers.
module multiply_divide_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  ALU_function_execute,
  input  logic [31:0] src_A_execute,
  input  logic [31:0] src_B_execute,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // state  | meaning
  // IDLE   | accepting MTHI/MTLO and new mul/div starts
  // RUN    | one multiply or divide iteration per cycle, 32 cycles
  // FINISH | sign fix-up; HI/LO written on the exit edge

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] operand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] orig_a;
  logic        is_div;
  logic        q_neg;
  logic        r_neg;
  logic        div_by_zero;

  logic        op_muldiv;
  logic        op_div;
  logic        op_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;

  logic [63:0] product;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    op_muldiv = (ALU_function_execute == FN_MULT) || (ALU_function_execute == FN_MULTU) ||
                (ALU_function_execute == FN_DIV)  || (ALU_function_execute == FN_DIVU);
    op_div    = (ALU_function_execute == FN_DIV)  || (ALU_function_execute == FN_DIVU);
    op_signed = (ALU_function_execute == FN_MULT) || (ALU_function_execute == FN_DIV);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    abs_a = (op_signed && src_A_execute[31]) ? -src_A_execute : src_A_execute;
    abs_b = (op_signed && src_B_execute[31]) ? -src_B_execute : src_B_execute;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_ge    = div_shift >= {1'b0, operand};
    // when div_ge holds the difference is below the divisor, so 32 bits suffice
    div_sub   = div_shift[31:0] - operand;
  end

  always_comb begin
    product  = {acc_hi, acc_lo};
    if (q_neg) begin
      product = -product;
    end
    quot_fix = q_neg ? -acc_lo : acc_lo;
    rem_fix  = r_neg ? -acc_hi : acc_hi;
    res_hi   = product[63:32];
    res_lo   = product[31:0];
    if (is_div) begin
      if (div_by_zero) begin
        res_hi = orig_a;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_fix;
        res_lo = quot_fix;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start && op_muldiv) state_next = S_RUN;
      S_RUN:    if (count == 5'd31) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= 5'd0;
      operand     <= 32'd0;
      acc_hi      <= 32'd0;
      acc_lo      <= 32'd0;
      orig_a      <= 32'd0;
      is_div      <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= 32'd0;
      LO          <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_muldiv) begin
              // divide: acc_lo holds the dividend, operand the divisor;
              // multiply: acc_lo holds the multiplier, operand the multiplicand
              operand     <= op_div ? abs_b : abs_a;
              acc_lo      <= op_div ? abs_a : abs_b;
              acc_hi      <= 32'd0;
              orig_a      <= src_A_execute;
              is_div      <= op_div;
              q_neg       <= op_signed && (src_A_execute[31] ^ src_B_execute[31]);
              r_neg       <= op_signed && op_div && src_A_execute[31];
              div_by_zero <= op_div && (src_B_execute == 32'd0);
              count       <= 5'd0;
            end else if (ALU_function_execute == FN_MTHI) begin
              HI <= src_A_execute;
            end else if (ALU_function_execute == FN_MTLO) begin
              LO <= src_A_execute;
            end
          end
        end
        S_RUN: begin
          count <= count + 5'd1;
          if (is_div) begin
            acc_hi <= div_ge ? div_sub : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_ge};
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
        end
        S_FINISH: begin
          HI <= res_hi;
          LO <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
